// File: rtl/operand_fetch.sv
// Operand fetch for the integer ALU: decodes RV64I OP/OP-IMM, reads a 32x64 register file
// with write-first forwarding, and registers the {instruction, in1, in2, rd} bundle.
module operand_fetch #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue_valid,
    input  logic [31:0]     instruction,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            op_valid,
    output logic [31:0]     op_instruction,
    output logic [XLEN-1:0] op_in1,
    output logic [XLEN-1:0] op_in2,
    output logic [4:0]      op_rd,
    output logic            illegal
);

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;

    logic [XLEN-1:0] regs_q [NREG];

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            legal;
    logic [XLEN-1:0] in2_d;
    logic [31:0]     instr_d;

    logic            op_valid_q;
    logic            illegal_q;
    logic [31:0]     op_instruction_q;
    logic [XLEN-1:0] op_in1_q;
    logic [XLEN-1:0] op_in2_q;
    logic [4:0]      op_rd_q;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    // Write-first: a same-cycle write-back to the source register wins over the array.
    always_comb begin
        rs1_val = '0;
        if (rs1 != 5'd0) begin
            if (wb_en && (wb_rd == rs1)) begin
                rs1_val = wb_data;
            end else begin
                rs1_val = regs_q[rs1];
            end
        end
    end

    always_comb begin
        rs2_val = '0;
        if (rs2 != 5'd0) begin
            if (wb_en && (wb_rd == rs2)) begin
                rs2_val = wb_data;
            end else begin
                rs2_val = regs_q[rs2];
            end
        end
    end

    always_comb begin
        legal   = 1'b0;
        in2_d   = '0;
        instr_d = instruction;
        if (opcode == OpcOp) begin
            legal = 1'b1;
            in2_d = rs2_val;
        end else if (opcode == OpcOpImm) begin
            legal = 1'b1;
            if ((funct3 == 3'd1) || (funct3 == 3'd5)) begin
                in2_d = {{(XLEN-6){1'b0}}, instruction[25:20]};
            end else begin
                in2_d = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
                // Keep a negative immediate from looking like SUB/SRA to the ALU.
                instr_d[30] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_valid_q       <= 1'b0;
            illegal_q        <= 1'b0;
            op_instruction_q <= '0;
            op_in1_q         <= '0;
            op_in2_q         <= '0;
            op_rd_q          <= '0;
        end else begin
            op_valid_q <= issue_valid && legal;
            illegal_q  <= issue_valid && !legal;
            if (issue_valid && legal) begin
                op_instruction_q <= instr_d;
                op_in1_q         <= rs1_val;
                op_in2_q         <= in2_d;
                op_rd_q          <= instruction[11:7];
            end
        end
    end

    assign op_valid       = op_valid_q;
    assign illegal        = illegal_q;
    assign op_instruction = op_instruction_q;
    assign op_in1         = op_in1_q;
    assign op_in2         = op_in2_q;
    assign op_rd          = op_rd_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed steps followed by random traffic checked
// against a behavioural register-file and decode model.
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic [31:0] instruction;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        op_valid;
    logic [31:0] op_instruction;
    logic [63:0] op_in1;
    logic [63:0] op_in2;
    logic [4:0]  op_rd;
    logic        illegal;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] m_regs [32];
    logic        e_valid;
    logic        e_illegal;
    logic [31:0] e_instr;
    logic [63:0] e_in1;
    logic [63:0] e_in2;
    logic [4:0]  e_rd;

    operand_fetch #(.XLEN(64), .NREG(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .instruction    (instruction),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .op_valid       (op_valid),
        .op_instruction (op_instruction),
        .op_in1         (op_in1),
        .op_in2         (op_in2),
        .op_rd          (op_rd),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        e_valid   = 1'b0;
        e_illegal = 1'b0;
        e_instr   = 32'd0;
        e_in1     = 64'd0;
        e_in2     = 64'd0;
        e_rd      = 5'd0;
    endtask

    function automatic logic [63:0] model_read(input logic [4:0] idx, input logic we,
                                               input logic [4:0] wrd, input logic [63:0] wd);
        if (idx == 5'd0) return 64'd0;
        if (we && wrd == idx) return wd;
        return m_regs[idx];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(op_valid), 64'(e_valid));
        chk({tag, ".illegal"}, 64'(illegal), 64'(e_illegal));
        chk({tag, ".instr"}, 64'(op_instruction), 64'(e_instr));
        chk({tag, ".in1"}, op_in1, e_in1);
        chk({tag, ".in2"}, op_in2, e_in2);
        chk({tag, ".rd"}, 64'(op_rd), 64'(e_rd));
    endtask

    // One clock: drive inputs, predict, cross the edge, compare.
    task automatic step(input string tag, input logic iv, input logic [31:0] ins,
                        input logic we, input logic [4:0] wrd, input logic [63:0] wd);
        logic [6:0] opc;
        logic [2:0] f3;
        logic       leg;
        issue_valid = iv;
        instruction = ins;
        wb_en       = we;
        wb_rd       = wrd;
        wb_data     = wd;
        opc = ins[6:0];
        f3  = ins[14:12];
        leg = (opc == 7'b0110011) || (opc == 7'b0010011);
        e_valid   = iv && leg;
        e_illegal = iv && !leg;
        if (iv && leg) begin
            e_in1 = model_read(ins[19:15], we, wrd, wd);
            e_rd  = ins[11:7];
            if (opc == 7'b0110011) begin
                e_in2   = model_read(ins[24:20], we, wrd, wd);
                e_instr = ins;
            end else if (f3 == 3'd1 || f3 == 3'd5) begin
                e_in2   = {58'd0, ins[25:20]};
                e_instr = ins;
            end else begin
                e_in2   = {{52{ins[31]}}, ins[31:20]};
                e_instr = ins & 32'hBFFF_FFFF;
            end
        end
        @(posedge clk);
        #1;
        if (we && wrd != 5'd0) m_regs[wrd] = wd;
        check_all(tag);
    endtask

    logic [31:0] rnd;
    logic [6:0]  ropc;
    logic [4:0]  rwrd;
    int          sel;

    initial begin
        rst_n       = 1'b0;
        issue_valid = 1'b0;
        instruction = 32'd0;
        wb_en       = 1'b0;
        wb_rd       = 5'd0;
        wb_data     = 64'd0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // add x3,x1,x2 on an empty register file
        step("t1", 1'b1, 32'h002081B3, 1'b0, 5'd0, 64'd0);
        chk("t1.rd_const", 64'(op_rd), 64'd3);

        step("t2.wb1", 1'b0, 32'd0, 1'b1, 5'd1, 64'd5);
        chk("t2.valid_drop", 64'(op_valid), 64'd0);
        step("t2.wb2", 1'b0, 32'd0, 1'b1, 5'd2, 64'd7);
        step("t2", 1'b1, 32'h002081B3, 1'b0, 5'd0, 64'd0);
        chk("t2.in1_const", op_in1, 64'd5);
        chk("t2.in2_const", op_in2, 64'd7);

        step("t3", 1'b1, 32'hFFF08293, 1'b0, 5'd0, 64'd0);
        chk("t3.in2_const", op_in2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3.instr_const", 64'(op_instruction), 64'hBFF08293);

        step("t4", 1'b1, 32'h4030D313, 1'b0, 5'd0, 64'd0);
        chk("t4.in2_const", op_in2, 64'd3);
        chk("t4.bit30", 64'(op_instruction[30]), 64'd1);

        step("t5a", 1'b1, 32'h002081B3, 1'b1, 5'd1, 64'h1234);
        chk("t5a.in1_const", op_in1, 64'h1234);
        step("t5b.wb0", 1'b0, 32'd0, 1'b1, 5'd0, 64'd99);
        step("t5b", 1'b1, 32'h000001B3, 1'b0, 5'd0, 64'd0);
        chk("t5b.in1_const", op_in1, 64'd0);
        chk("t5b.in2_const", op_in2, 64'd0);

        step("t6.jal", 1'b1, 32'h0000006F, 1'b0, 5'd0, 64'd0);
        chk("t6.illegal_const", 64'(illegal), 64'd1);
        step("t6.after", 1'b0, 32'd0, 1'b0, 5'd0, 64'd0);
        chk("t6.illegal_pulse", 64'(illegal), 64'd0);

        step("t6.add", 1'b1, 32'h002081B3, 1'b0, 5'd0, 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6.midreset");
        @(negedge clk);
        rst_n = 1'b1;
        step("t6.post", 1'b1, 32'h002081B3, 1'b0, 5'd0, 64'd0);
        chk("t6.x1_cleared", op_in1, 64'd0);

        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) ropc = 7'b0110011;
            else if (sel < 8) ropc = 7'b0010011;
            else ropc = rnd[6:0] | 7'b0000100;
            rwrd = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) rwrd = rnd[19:15];
            step("rand", ($urandom_range(0, 4) != 0), {rnd[31:7], ropc},
                 1'($urandom_range(0, 1)), rwrd, {$urandom, $urandom});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
